fm_tune_ctrl: RTL and testbench



---
 rtl/fm_tune_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_fm_tune_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fm_tune_ctrl.sv
// FM carrier tuner: debounced up/down buttons step cw_freq across the band,
// with audio faded out, retuned, settled and faded back in for every change.
module fm_tune_ctrl #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_CYCLES   = 6250000,
    parameter int MUTE_CYCLES     = 2500,
    parameter int FREQ_MIN        = 87500000,
    parameter int FREQ_MAX        = 108000000,
    parameter int FREQ_STEP       = 100000,
    parameter int FREQ_RESET      = 108000000
) (
    input  logic        clk_25m,
    input  logic        reset,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic [15:0] pcm_in,
    output logic [15:0] pcm_out,
    output logic [31:0] cw_freq,
    output logic [7:0]  channel,
    output logic        retune,
    output logic        busy
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RP_W = $clog2(REPEAT_CYCLES + 1);
    localparam int MT_W = $clog2(MUTE_CYCLES + 1);

    localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RP_W-1:0] RP_LAST  = RP_W'(REPEAT_CYCLES - 1);
    localparam logic [MT_W-1:0] MT_LOAD  = MT_W'(MUTE_CYCLES);
    localparam logic [31:0]     F_MIN    = 32'(FREQ_MIN);
    localparam logic [31:0]     F_MAX    = 32'(FREQ_MAX);
    localparam logic [31:0]     F_STEP   = 32'(FREQ_STEP);
    localparam logic [31:0]     F_RESET  = 32'(FREQ_RESET);
    localparam logic [7:0]      CH_MAX   = 8'((FREQ_MAX - FREQ_MIN) / FREQ_STEP);
    localparam logic [7:0]      CH_RESET = 8'((FREQ_RESET - FREQ_MIN) / FREQ_STEP);
    localparam logic [8:0]      GAIN_FULL = 9'd256;

    typedef enum logic [1:0] {IDLE, FADE_OUT, SETTLE, FADE_IN} state_t;

    // Bit 0 is the up button, bit 1 the down button.
    logic [1:0]            sync1_q, sync1_d, sync2_q, sync2_d, deb_q, deb_d, ev;
    logic [1:0][DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic [1:0][RP_W-1:0]  rep_cnt_q, rep_cnt_d;
    logic                  step_any, step_up;

    state_t                state_q, state_d;
    logic [8:0]            gain_q, gain_d;
    logic [MT_W-1:0]       timer_q, timer_d;
    logic                  dir_q, dir_d, pend_q, pend_d, pend_dir_q, pend_dir_d;
    logic                  apply, apply_up;

    logic [31:0]           freq_q, freq_d;
    logic [7:0]            chan_q, chan_d;
    logic                  retune_q, retune_d;
    logic [15:0]           pcm_out_q, pcm_out_d;
    logic signed [25:0]    pcm_ext, gain_ext, prod;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        sync1_d   = {btn_down, btn_up};
        sync2_d   = sync1_q;
        deb_d     = deb_q;
        ev        = '0;
        db_cnt_d  = '0;
        rep_cnt_d = '0;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != deb_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) deb_d[i] = sync2_q[i];
                else                        db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
            end
            if (deb_d[i] && !deb_q[i]) begin
                ev[i] = 1'b1;
            end else if (deb_d[i]) begin
                if (rep_cnt_q[i] == RP_LAST) ev[i] = 1'b1;
                else                         rep_cnt_d[i] = rep_cnt_q[i] + RP_W'(1);
            end
        end
        // Simultaneous events cancel, and holding both buttons blocks repeats.
        step_any = (ev[0] ^ ev[1]) && !(&deb_d);
        step_up  = ev[0];
    end

    always_comb begin
        state_d    = state_q;
        gain_d     = gain_q;
        timer_d    = timer_q;
        dir_d      = dir_q;
        pend_d     = pend_q;
        pend_dir_d = pend_dir_q;
        apply      = 1'b0;
        apply_up   = dir_q;
        unique case (state_q)
            IDLE: begin
                if (step_any) begin
                    dir_d   = step_up;
                    state_d = FADE_OUT;
                end else if (pend_q) begin
                    dir_d   = pend_dir_q;
                    pend_d  = 1'b0;
                    state_d = FADE_OUT;
                end
            end
            FADE_OUT: begin
                gain_d = gain_q - 9'd1;
                if (gain_q <= 9'd1) begin
                    gain_d  = '0;
                    apply   = 1'b1;
                    timer_d = MT_LOAD;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - MT_W'(1);
                end else if (pend_q) begin
                    apply    = 1'b1;
                    apply_up = pend_dir_q;
                    pend_d   = 1'b0;
                    timer_d  = MT_LOAD;
                end else begin
                    state_d = FADE_IN;
                end
            end
            FADE_IN: begin
                gain_d = gain_q + 9'd1;
                if (gain_d == GAIN_FULL) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Events during a retune coalesce into one request; the newest direction wins.
        if (state_q != IDLE && step_any) begin
            pend_d     = 1'b1;
            pend_dir_d = step_up;
        end
    end

    always_comb begin
        freq_d   = freq_q;
        chan_d   = chan_q;
        retune_d = apply;
        if (apply) begin
            if (apply_up) begin
                if (freq_q >= F_MAX) begin
                    freq_d = F_MIN;
                    chan_d = '0;
                end else begin
                    freq_d = freq_q + F_STEP;
                    chan_d = chan_q + 8'd1;
                end
            end else begin
                if (freq_q <= F_MIN) begin
                    freq_d = F_MAX;
                    chan_d = CH_MAX;
                end else begin
                    freq_d = freq_q - F_STEP;
                    chan_d = chan_q - 8'd1;
                end
            end
        end
        pcm_ext   = {{10{pcm_in[15]}}, pcm_in};
        gain_ext  = {17'd0, gain_q};
        prod      = pcm_ext * gain_ext;
        pcm_out_d = 16'(prod >>> 8);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_25m) begin
        if (reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            db_cnt_q   <= '0;
            rep_cnt_q  <= '0;
            state_q    <= IDLE;
            gain_q     <= GAIN_FULL;
            timer_q    <= '0;
            dir_q      <= 1'b0;
            pend_q     <= 1'b0;
            pend_dir_q <= 1'b0;
            freq_q     <= F_RESET;
            chan_q     <= CH_RESET;
            retune_q   <= 1'b0;
            pcm_out_q  <= '0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            deb_q      <= deb_d;
            db_cnt_q   <= db_cnt_d;
            rep_cnt_q  <= rep_cnt_d;
            state_q    <= state_d;
            gain_q     <= gain_d;
            timer_q    <= timer_d;
            dir_q      <= dir_d;
            pend_q     <= pend_d;
            pend_dir_q <= pend_dir_d;
            freq_q     <= freq_d;
            chan_q     <= chan_d;
            retune_q   <= retune_d;
            pcm_out_q  <= pcm_out_d;
        end
    end

    assign pcm_out = pcm_out_q;
    assign cw_freq = freq_q;
    assign channel = chan_q;
    assign retune  = retune_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_fm_tune_ctrl.sv
// Self-checking bench for fm_tune_ctrl: directed retune sequences, a pcm
// vector table, and randomized presses checked against a channel-index model.
module tb_fm_tune_ctrl;

    localparam int FMIN  = 87500000;
    localparam int FMAX  = 108000000;
    localparam int FSTEP = 100000;
    localparam int NCH   = (FMAX - FMIN) / FSTEP + 1;

    logic        clk_25m = 1'b0;
    logic        reset;
    logic        btn_up, btn_down;
    logic [15:0] pcm_in;
    logic [15:0] pcm_out;
    logic [31:0] cw_freq;
    logic [7:0]  channel;
    logic        retune, busy;

    int n_checks = 0;
    int n_fail   = 0;

    fm_tune_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_CYCLES  (64),
        .MUTE_CYCLES    (8)
    ) dut (
        .clk_25m (clk_25m),
        .reset   (reset),
        .btn_up  (btn_up),
        .btn_down(btn_down),
        .pcm_in  (pcm_in),
        .pcm_out (pcm_out),
        .cw_freq (cw_freq),
        .channel (channel),
        .retune  (retune),
        .busy    (busy)
    );

    always #5 clk_25m = ~clk_25m;

    // Passive statistics sampled on the falling edge.
    int          retune_total     = 0;
    int          busy_total       = 0;
    int          bad_change_total = 0;
    int          bad_chan_total   = 0;
    logic [31:0] prev_freq;
    logic        retune_prev      = 1'b0;
    logic [15:0] pcm_after_retune = 16'hffff;

    always @(negedge clk_25m) begin
        if (retune) retune_total <= retune_total + 1;
        if (busy)   busy_total   <= busy_total + 1;
        if (retune_prev) pcm_after_retune <= pcm_out;
        if (!reset && (cw_freq != prev_freq) && !retune) bad_change_total <= bad_change_total + 1;
        if (retune && (channel != 8'((cw_freq - FMIN) / FSTEP))) bad_chan_total <= bad_chan_total + 1;
        retune_prev <= retune;
        prev_freq   <= cw_freq;
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk_25m);
    endtask

    task automatic press(input logic up, input logic dn, input int len);
        btn_up   = up;
        btn_down = dn;
        tick(len);
        btn_up   = 1'b0;
        btn_down = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (busy && k < 3000) begin
            tick();
            k++;
        end
        check(name, busy, 0);
    endtask

    typedef struct {
        logic signed [15:0] pcm;
        logic signed [15:0] exp_out;
        logic [31:0]        exp_freq;
        logic               exp_busy;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int r0, b0, bl, model_idx, k;
        logic dir;
        logic [15:0] q[$];
        logic [15:0] v;

        vecs[0] = '{16'sd1000,   16'sd1000,   32'(FMAX), 1'b0};
        vecs[1] = '{-16'sd1000,  -16'sd1000,  32'(FMAX), 1'b0};
        vecs[2] = '{16'sd32767,  16'sd32767,  32'(FMAX), 1'b0};
        vecs[3] = '{-16'sd32768, -16'sd32768, 32'(FMAX), 1'b0};
        vecs[4] = '{16'sd1,      16'sd1,      32'(FMAX), 1'b0};
        vecs[5] = '{-16'sd1,     -16'sd1,     32'(FMAX), 1'b0};
        vecs[6] = '{16'sd1000,   16'sd1000,   32'(FMAX), 1'b0};

        // Reset and idle behaviour
        reset = 1'b1; btn_up = 1'b0; btn_down = 1'b0; pcm_in = 16'd1000;
        tick(3);
        reset = 1'b0;
        check("reset_freq",    cw_freq, FMAX);
        check("reset_channel", channel, 205);
        check("reset_busy",    busy, 0);
        check("reset_retune",  retune, 0);
        check("reset_pcm_out", pcm_out, 0);
        tick();
        check("pcm_latency_first", $signed(pcm_out), 1000);

        for (int i = 0; i < 7; i++) begin
            pcm_in = vecs[i].pcm;
            #1;
            check("pcm_not_combinational", $signed(pcm_out), (i == 0) ? 1000 : vecs[i-1].exp_out);
            tick();
            check("pcm_table_out",  $signed(pcm_out), vecs[i].exp_out);
            check("pcm_table_freq", cw_freq, vecs[i].exp_freq);
            check("pcm_table_busy", busy, vecs[i].exp_busy);
        end

        // Single up press at the top of the band wraps to the bottom
        pcm_in = 16'd1000;
        tick(2);
        r0 = retune_total; b0 = busy_total;
        press(1'b1, 1'b0, 20);
        wait_idle("single_up_idle_timeout");
        tick(2);
        bl = busy_total - b0;
        check("single_up_retunes",      retune_total - r0, 1);
        check("single_up_freq",         cw_freq, FMIN);
        check("single_up_channel",      channel, 0);
        check("single_up_muted_at_pulse", pcm_after_retune, 0);
        check("single_up_busy_len_ok",  (bl >= 518 && bl <= 522), 1);
        check("single_up_pcm_restored", $signed(pcm_out), 1000);

        // Short glitch must be rejected by the debouncer
        r0 = retune_total; b0 = busy_total;
        press(1'b0, 1'b1, 3);
        tick(50);
        check("glitch_retunes", retune_total - r0, 0);
        check("glitch_busy",    busy_total - b0, 0);
        check("glitch_freq",    cw_freq, FMIN);

        // Held down button: first step plus three coalesced repeats
        press(1'b1, 1'b0, 20);
        wait_idle("prep_up_idle_timeout");
        tick(2);
        check("prep_up_freq", cw_freq, FMIN + FSTEP);
        r0 = retune_total;
        press(1'b0, 1'b1, 200);
        wait_idle("hold_down_idle_timeout");
        tick(2);
        check("hold_down_retunes", retune_total - r0, 2);
        check("hold_down_freq",    cw_freq, FMAX);
        check("hold_down_channel", channel, 205);

        // Both buttons in the same cycle cancel
        r0 = retune_total; b0 = busy_total;
        press(1'b1, 1'b1, 20);
        tick(30);
        check("both_retunes", retune_total - r0, 0);
        check("both_busy",    busy_total - b0, 0);
        check("both_freq",    cw_freq, FMAX);

        // Reset in the middle of a fade, with a request pending
        btn_up = 1'b1;
        k = 0;
        while (!busy && k < 30) begin
            tick();
            k++;
        end
        check("midfade_started", busy, 1);
        for (int n = 1; n <= 156; n++) begin
            tick();
            if (n == 14) btn_up = 1'b0;
            if (n == 50) btn_up = 1'b1;
            if (n == 70) btn_up = 1'b0;
        end
        reset = 1'b1;
        tick();
        check("midfade_reset_busy",    busy, 0);
        check("midfade_reset_freq",    cw_freq, FMAX);
        check("midfade_reset_channel", channel, 205);
        check("midfade_reset_pcm",     pcm_out, 0);
        check("midfade_reset_retune",  retune, 0);
        reset = 1'b0;
        tick();
        check("midfade_gain_full", $signed(pcm_out), 1000);
        r0 = retune_total; b0 = busy_total;
        tick(600);
        check("midfade_pending_cleared_retunes", retune_total - r0, 0);
        check("midfade_pending_cleared_busy",    busy_total - b0, 0);

        // Randomized presses against a channel-index model, with pcm bursts in between
        model_idx = (FMAX - FMIN) / FSTEP;
        for (int t = 0; t < 6; t++) begin
            for (int j = 0; j < 8; j++) begin
                v = 16'($urandom);
                q.push_back(v);
                pcm_in = v;
                tick();
                check("rand_pcm_delay", pcm_out, q.pop_front());
            end
            pcm_in = 16'd500;
            dir = 1'($urandom_range(0, 1));
            press(dir, !dir, $urandom_range(8, 50));
            wait_idle("rand_idle_timeout");
            tick(2);
            model_idx = dir ? (model_idx + 1) % NCH : (model_idx + NCH - 1) % NCH;
            check("rand_freq",    cw_freq, FMIN + model_idx * FSTEP);
            check("rand_channel", channel, model_idx);
        end

        check("freq_changes_only_on_retune", bad_change_total, 0);
        check("channel_tracks_freq",         bad_chan_total, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
